// File: rtl/acl2_spi_responder_pkg.sv
// Shared constants for the ADXL362-style SPI register responder: commands, register map, FSM encodings.
package acl2_spi_responder_pkg;

    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
    localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
    localparam logic [5:0] ADDR_PART_ID   = 6'h02;
    localparam logic [5:0] ADDR_XDATA     = 6'h08;
    localparam logic [5:0] ADDR_YDATA     = 6'h09;
    localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
    localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
    localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
    localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
    localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
    localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
    localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
    localparam logic [5:0] ADDR_SOFT_RST  = 6'h1F;
    localparam logic [5:0] ADDR_FILTER    = 6'h2C;
    localparam logic [5:0] ADDR_POWER     = 6'h2D;

    localparam logic [7:0] FILTER_CTL_RST = 8'h13;
    localparam logic [7:0] POWER_CTL_RST  = 8'h00;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_RD     = 3'd3;
    localparam logic [2:0] ST_WR     = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    // High data byte: sign-extended top nibble of a 12-bit sample.
    function automatic logic [7:0] sign_hi(input logic [11:0] v);
        return {{4{v[11]}}, v[11:8]};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with a history flop; reports level plus one-clk rise/fall pulses.
// Latency STAGES clk to level and edge pulses; no backpressure (free-running).
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Deliberately unreset: the history flop always tracks the level, so a reset can never fabricate an edge.
    always_ff @(posedge clk) begin
        chain <= {chain[STAGES-2:0], din};
        prev  <= chain[STAGES-1];
    end

    assign lvl  = chain[STAGES-1];
    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/acl2_spi_responder.sv
// SPI mode-0 slave emulating the ADXL362 register protocol over a 64-byte map with snapshotted accel data.
// Latency: wr_valid SYNC_STAGES+1 clk after the 8th data sclk rise; no backpressure (master owns the clock).
module acl2_spi_responder
    import acl2_spi_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PART_ID     = 8'hF2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [11:0] acc_x,
    input  logic [11:0] acc_y,
    input  logic [11:0] acc_z,
    output logic [7:0]  power_ctl,
    output logic [7:0]  filter_ctl,
    output logic        wr_valid,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_rise, sclk_fall, unused_sclk_lvl;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk (clk), .din (spi_cs), .lvl (cs_lvl), .rise (cs_rise), .fall (cs_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk (clk), .din (spi_sclk), .lvl (unused_sclk_lvl), .rise (sclk_rise), .fall (sclk_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk (clk), .din (spi_mosi), .lvl (mosi_lvl), .rise (unused_mosi_rise), .fall (unused_mosi_fall)
    );

    logic [2:0]  state;
    logic        is_rd;
    logic [2:0]  i;
    logic [6:0]  sr;
    logic [5:0]  ptr;
    logic [7:0]  tx;
    logic        load_pend;
    logic [11:0] snap_x, snap_y, snap_z;
    logic [7:0]  byte_in;
    logic [7:0]  rd_byte;
    logic        shifting;

    assign byte_in  = {sr, mosi_lvl};
    assign shifting = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_RD) || (state == ST_WR);
    assign spi_miso = (state == ST_RD) ? tx[7] : 1'b0;

    always_comb begin
        rd_byte = 8'h00;
        case (ptr)
            ADDR_DEVID_AD:  rd_byte = DEVID_AD;
            ADDR_DEVID_MST: rd_byte = DEVID_MST;
            ADDR_PART_ID:   rd_byte = PART_ID;
            ADDR_XDATA:     rd_byte = snap_x[11:4];
            ADDR_YDATA:     rd_byte = snap_y[11:4];
            ADDR_ZDATA:     rd_byte = snap_z[11:4];
            ADDR_XDATA_L:   rd_byte = snap_x[7:0];
            ADDR_XDATA_H:   rd_byte = sign_hi(snap_x);
            ADDR_YDATA_L:   rd_byte = snap_y[7:0];
            ADDR_YDATA_H:   rd_byte = sign_hi(snap_y);
            ADDR_ZDATA_L:   rd_byte = snap_z[7:0];
            ADDR_ZDATA_H:   rd_byte = sign_hi(snap_z);
            ADDR_FILTER:    rd_byte = filter_ctl;
            ADDR_POWER:     rd_byte = power_ctl;
            default:        rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            is_rd      <= 1'b0;
            i          <= 3'd0;
            sr         <= 7'd0;
            ptr        <= 6'd0;
            tx         <= 8'd0;
            load_pend  <= 1'b0;
            snap_x     <= 12'd0;
            snap_y     <= 12'd0;
            snap_z     <= 12'd0;
            power_ctl  <= POWER_CTL_RST;
            filter_ctl <= FILTER_CTL_RST;
            wr_valid   <= 1'b0;
            wr_addr    <= 6'd0;
            wr_data    <= 8'd0;
            busy       <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            busy     <= ~cs_lvl;
            // cs rise takes priority over a coincident sclk edge, dropping any partial byte.
            if (cs_rise) begin
                state     <= ST_IDLE;
                load_pend <= 1'b0;
            end else if (cs_fall && state == ST_IDLE) begin
                snap_x    <= acc_x;
                snap_y    <= acc_y;
                snap_z    <= acc_z;
                i         <= 3'd0;
                load_pend <= 1'b0;
                state     <= ST_CMD;
            end else if (sclk_rise && shifting) begin
                sr <= byte_in[6:0];
                i  <= i + 3'd1;
                if (i == 3'd7) begin
                    case (state)
                        ST_CMD: begin
                            if (byte_in == CMD_READ) begin
                                is_rd <= 1'b1;
                                state <= ST_ADDR;
                            end else if (byte_in == CMD_WRITE) begin
                                is_rd <= 1'b0;
                                state <= ST_ADDR;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                        ST_ADDR: begin
                            ptr <= byte_in[5:0];
                            tx  <= 8'd0;
                            if (is_rd) begin
                                state     <= ST_RD;
                                load_pend <= 1'b1;
                            end else begin
                                state <= ST_WR;
                            end
                        end
                        ST_RD: begin
                            ptr       <= ptr + 6'd1;
                            load_pend <= 1'b1;
                        end
                        ST_WR: begin
                            wr_valid <= 1'b1;
                            wr_addr  <= ptr;
                            wr_data  <= byte_in;
                            ptr      <= ptr + 6'd1;
                            if (ptr == ADDR_FILTER) begin
                                filter_ctl <= byte_in;
                            end else if (ptr == ADDR_POWER) begin
                                power_ctl <= byte_in;
                            end else if (ptr == ADDR_SOFT_RST && byte_in == SOFT_RESET_KEY) begin
                                power_ctl  <= POWER_CTL_RST;
                                filter_ctl <= FILTER_CTL_RST;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (sclk_fall && state == ST_RD) begin
                if (load_pend) begin
                    tx        <= rd_byte;
                    load_pend <= 1'b0;
                end else begin
                    tx <= {tx[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_acl2_spi_responder.sv
// Directed plus randomized bench for acl2_spi_responder against a register-image model.
module tb_acl2_spi_responder;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs, spi_sclk, spi_mosi, spi_miso;
    logic [11:0] acc_x, acc_y, acc_z;
    logic [7:0]  power_ctl, filter_ctl, wr_data;
    logic        wr_valid, busy;
    logic [5:0]  wr_addr;

    acl2_spi_responder dut (
        .clk        (clk),
        .rst        (rst),
        .spi_cs     (spi_cs),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .acc_x      (acc_x),
        .acc_y      (acc_y),
        .acc_z      (acc_z),
        .power_ctl  (power_ctl),
        .filter_ctl (filter_ctl),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] wr_q[$];
    logic [13:0] exp_wr[$];
    logic [7:0]  m_power, m_filter;
    logic [11:0] sx, sy, sz;

    always @(negedge clk) if (wr_valid === 1'b1) wr_q.push_back({wr_addr, wr_data});

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hi_byte(input logic [11:0] v);
        return 8'(v >> 8) | (v[11] ? 8'hF0 : 8'h00);
    endfunction

    // Register image seen by the master during the current transaction.
    function automatic logic [7:0] model_byte(input int a);
        logic [7:0] img [64];
        for (int k = 0; k < 64; k++) img[k] = 8'h00;
        img[8'h00] = 8'hAD; img[8'h01] = 8'h1D; img[8'h02] = 8'hF2;
        img[8'h08] = 8'(sx >> 4); img[8'h09] = 8'(sy >> 4); img[8'h0A] = 8'(sz >> 4);
        img[8'h0E] = sx[7:0]; img[8'h0F] = hi_byte(sx);
        img[8'h10] = sy[7:0]; img[8'h11] = hi_byte(sy);
        img[8'h12] = sz[7:0]; img[8'h13] = hi_byte(sz);
        img[8'h2C] = m_filter; img[8'h2D] = m_power;
        return img[a % 64];
    endfunction

    task automatic model_write(input int a, input logic [7:0] d);
        exp_wr.push_back({6'(a), d});
        if (a == 8'h2C) m_filter = d;
        else if (a == 8'h2D) m_power = d;
        else if (a == 8'h1F && d == 8'h52) begin
            m_power  = 8'h00;
            m_filter = 8'h13;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        m_power  = 8'h00;
        m_filter = 8'h13;
    endtask

    task automatic cs_begin();
        sx = acc_x; sy = acc_y; sz = acc_z;
        spi_cs = 1'b0;
        #(HALF);
        check("busy_active", busy, 1);
    endtask

    task automatic cs_end();
        #(HALF);
        spi_cs = 1'b1;
        #(3 * HALF);
        check("busy_idle", busy, 0);
    endtask

    task automatic xfer(input logic [7:0] txb, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = txb[7 - b];
            #(HALF);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            #(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic rd_burst(input logic [5:0] a, input int n, input string tag, input bit wobble);
        logic [7:0] rx;
        cs_begin();
        xfer(8'h0B, 8, rx);
        xfer({2'($urandom), a}, 8, rx);
        for (int k = 0; k < n; k++) begin
            xfer(8'($urandom), 8, rx);
            check(tag, rx, model_byte(int'(a) + k));
            if (wobble) begin
                acc_x = 12'($urandom); acc_y = 12'($urandom); acc_z = 12'($urandom);
            end
        end
        cs_end();
    endtask

    task automatic wr_burst(input logic [5:0] a, input int n, input logic [31:0] data);
        logic [7:0] rx;
        logic [7:0] d;
        cs_begin();
        xfer(8'h0A, 8, rx);
        xfer({2'b00, a}, 8, rx);
        for (int k = 0; k < n; k++) begin
            d = 8'(data >> (8 * (3 - k)));
            xfer(d, 8, rx);
            model_write((int'(a) + k) % 64, d);
        end
        cs_end();
    endtask

    task automatic verify_writes(input string tag);
        int n;
        check({tag, "_count"}, wr_q.size(), exp_wr.size());
        n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int k = 0; k < n; k++) check({tag, "_entry"}, wr_q[k], exp_wr[k]);
        wr_q.delete();
        exp_wr.delete();
    endtask

    initial begin
        logic [7:0] rx;
        logic [5:0] a;
        int         n;
        logic [31:0] data;

        rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        acc_x = 12'h000; acc_y = 12'h000; acc_z = 12'h000;
        @(negedge clk);
        do_reset();
        check("rst_miso", spi_miso, 0);
        check("rst_power", power_ctl, 8'h00);
        check("rst_filter", filter_ctl, 8'h13);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);

        rd_burst(6'h00, 3, "id_burst", 1'b0);

        acc_x = 12'hF83; acc_y = 12'h123; acc_z = 12'h7FF;
        rd_burst(6'h0E, 2, "xdata_coherent", 1'b1);
        acc_x = 12'h5A7;
        rd_burst(6'h08, 3, "xyz_msb", 1'b0);

        wr_burst(6'h2D, 1, 32'h0200_0000);
        wr_burst(6'h2C, 1, 32'h1300_0000);
        verify_writes("wr_ctl");
        check("power_after_wr", power_ctl, 8'h02);
        check("filter_after_wr", filter_ctl, 8'h13);

        cs_begin();
        xfer(8'h0C, 8, rx);
        for (int k = 0; k < 3; k++) begin
            xfer(8'($urandom), 8, rx);
            check("ignore_miso", rx, 0);
        end
        cs_end();
        verify_writes("ignore_wr");
        rd_burst(6'h2D, 1, "after_ignore", 1'b0);

        cs_begin();
        xfer(8'h0A, 8, rx);
        xfer(8'h2D, 8, rx);
        xfer(8'hC5, 5, rx);
        cs_end();
        verify_writes("partial_wr");
        check("partial_power", power_ctl, m_power);

        cs_begin();
        xfer(8'h0B, 8, rx);
        xfer(8'h00, 4, rx);
        do_reset();
        cs_end();
        rd_burst(6'h00, 1, "after_rst", 1'b0);
        check("rst_mid_power", power_ctl, 8'h00);

        rd_burst(6'h3F, 2, "wrap_read", 1'b0);
        wr_burst(6'h2D, 1, {8'h08, 24'h0});
        wr_burst(6'h2C, 1, {8'h40, 24'h0});
        wr_burst(6'h1F, 1, 32'h5200_0000);
        verify_writes("soft_rst_wr");
        check("soft_rst_power", power_ctl, 8'h00);
        check("soft_rst_filter", filter_ctl, 8'h13);

        for (int it = 0; it < 15; it++) begin
            acc_x = 12'($urandom); acc_y = 12'($urandom); acc_z = 12'($urandom);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 19)) : 6'($urandom);
                rd_burst(a, n + 1, "rand_read", 1'b1);
            end else begin
                case ($urandom_range(0, 3))
                    0: a = 6'h2C;
                    1: a = 6'h2B;
                    2: a = 6'h1F;
                    default: a = 6'($urandom);
                endcase
                data = $urandom;
                if ($urandom_range(0, 2) == 0) data[31:24] = 8'h52;
                wr_burst(a, n, data);
                verify_writes("rand_wr");
                check("rand_power", power_ctl, m_power);
                check("rand_filter", filter_ctl, m_filter);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
